param_updown_counter: RTL and testbench

//   Parametrised up/down counter; successor to the fixed 8-bit preset/clear counter.

---
 rtl/param_updown_counter.sv | 127 ++++++++++++
 tb/tb_param_updown_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with preset, clamped parallel load, wrap or saturate
// limits and wrap/overflow status. Define COUNTER_MATCH_EN to add the registered match compare.
module param_updown_counter #(
    parameter int WIDTH        = 8,
    parameter int MODULUS      = 1 << WIDTH,
    parameter int PRESET_VALUE = MODULUS - 1,
    parameter bit SATURATE     = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             preset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    input  logic             up,
`ifdef COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] match_value,
    output logic             match,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);
    // One bit of headroom so MODULUS = 2^WIDTH still has an exact upper limit.
    localparam logic [WIDTH:0]   LIMIT_C  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] PRESET_C = WIDTH'(PRESET_VALUE);
    localparam logic [WIDTH:0]   ONE_C    = (WIDTH+1)'(1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_r;
    logic             wrap_next_s;
    logic             ovf_r;
    logic             ovf_next_s;
    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic             at_top_s;
    logic             at_zero_s;

    assign q_ext_s   = {1'b0, q_r};
    assign inc_s     = q_ext_s + ONE_C;
    assign dec_s     = q_ext_s - ONE_C;
    assign at_top_s  = (q_ext_s == LIMIT_C);
    assign at_zero_s = (q_r == {WIDTH{1'b0}});

    // Next-state selection: preset > load > count > hold (clear handled in the register).
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        ovf_next_s  = ovf_r;
        if (preset) begin
            q_next_s   = PRESET_C;
            ovf_next_s = 1'b0;
        end else if (load) begin
            if ({1'b0, load_data} > LIMIT_C) begin
                q_next_s = LIMIT_C[WIDTH-1:0];
            end else begin
                q_next_s = load_data;
            end
            ovf_next_s = 1'b0;
        end else if (enable) begin
            if (up) begin
                if (at_top_s) begin
                    ovf_next_s = 1'b1;
                    if (SATURATE) begin
                        q_next_s = q_r;
                    end else begin
                        q_next_s    = {WIDTH{1'b0}};
                        wrap_next_s = 1'b1;
                    end
                end else begin
                    q_next_s = WIDTH'(inc_s);
                end
            end else begin
                if (at_zero_s) begin
                    ovf_next_s = 1'b1;
                    if (SATURATE) begin
                        q_next_s = q_r;
                    end else begin
                        q_next_s    = LIMIT_C[WIDTH-1:0];
                        wrap_next_s = 1'b1;
                    end
                end else begin
                    q_next_s = WIDTH'(dec_s);
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Counter and status registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            q_r    <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
            ovf_r  <= ovf_next_s;
        end
    end

`ifdef COUNTER_MATCH_EN
    logic match_r;

    // Compare against the next state so match lines up with the q it describes.
    always_ff @(posedge clock) begin
        if (clear) begin
            match_r <= 1'b0;
        end else begin
            match_r <= (q_next_s == match_value);
        end
    end

    assign match = match_r;
`endif

    assign q    = q_r;
    assign wrap = wrap_r;
    assign ovf  = ovf_r;
    assign tc   = up ? at_top_s : at_zero_s;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a wrapping and a saturating instance (MODULUS=10)
// share one stimulus stream and are checked every cycle against an arithmetic model.
module tb_param_updown_counter;
    localparam int W = 8;
    localparam int M = 10;
    localparam int P = 9;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         preset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_data = 8'd0;
    logic         enable = 1'b0;
    logic         up = 1'b1;
    logic [W-1:0] q0, q1;
    logic         tc0, tc1, wrap0, wrap1, ovf0, ovf1;
`ifdef COUNTER_MATCH_EN
    logic [W-1:0] match_value = 8'd7;
    logic         match0, match1;
`endif

    int  total = 0;
    int  passed = 0;
    int  mq[2];
    bit  mw[2];
    bit  mo[2];
    bit  mm[2];
    bit  valid = 1'b0;

    always #5 clock = ~clock;

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESET_VALUE(P), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .clear(clear), .preset(preset), .load(load), .load_data(load_data),
        .enable(enable), .up(up),
`ifdef COUNTER_MATCH_EN
        .match_value(match_value), .match(match0),
`endif
        .q(q0), .tc(tc0), .wrap(wrap0), .ovf(ovf0));

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESET_VALUE(P), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .clear(clear), .preset(preset), .load(load), .load_data(load_data),
        .enable(enable), .up(up),
`ifdef COUNTER_MATCH_EN
        .match_value(match_value), .match(match1),
`endif
        .q(q1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: the value the count would reach, folded back into 0..M-1 if it left the range.
    function automatic int next_q(input int cur, input bit sat);
        int r;
        if (preset) return P;
        if (load) return (int'(load_data) >= M) ? M - 1 : int'(load_data);
        if (!enable) return cur;
        r = up ? cur + 1 : cur - 1;
        if (r >= 0 && r < M) return r;
        if (sat) return cur;
        return (r + M) % M;
    endfunction

    function automatic bit limit_hit(input int cur);
        int r;
        r = up ? cur + 1 : cur - 1;
        return !preset && !load && enable && (r < 0 || r >= M);
    endfunction

    always @(posedge clock) begin
        for (int s = 0; s < 2; s++) begin
            mq[s] <= clear ? 0 : next_q(mq[s], s == 1);
            mm[s] <= clear ? 1'b0 : 1'b0;
`ifdef COUNTER_MATCH_EN
            mm[s] <= clear ? 1'b0 : (next_q(mq[s], s == 1) == int'(match_value));
`endif
            mw[s] <= !clear && (s == 0) && limit_hit(mq[s]);
            mo[s] <= clear || preset || load ? 1'b0 : (limit_hit(mq[s]) ? 1'b1 : mo[s]);
        end
        valid <= valid | clear;
    end

    function automatic int tc_model(input int s);
        return up ? int'(mq[s] == M - 1) : int'(mq[s] == 0);
    endfunction

    always @(negedge clock) begin
        if (valid) begin
            chk("q_wrap", int'(q0), mq[0]);
            chk("q_sat", int'(q1), mq[1]);
            chk("tc_wrap", int'(tc0), tc_model(0));
            chk("tc_sat", int'(tc1), tc_model(1));
            chk("wrap_wrap", int'(wrap0), int'(mw[0]));
            chk("wrap_sat", int'(wrap1), int'(mw[1]));
            chk("ovf_wrap", int'(ovf0), int'(mo[0]));
            chk("ovf_sat", int'(ovf1), int'(mo[1]));
`ifdef COUNTER_MATCH_EN
            chk("match_wrap", int'(match0), int'(mm[0]));
            chk("match_sat", int'(match1), int'(mm[1]));
`endif
        end
    end

    task automatic step(input bit c, input bit p, input bit l, input int d, input bit e, input bit u);
        clear = c; preset = p; load = l; load_data = W'(d); enable = e; up = u;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: clear two edges, then count up through the wrap
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("t1_reset_q", int'(q0), 0);
        chk("t1_reset_ovf", int'(ovf0), 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 1, 1);
            if (i == 9) begin
                chk("t1_q9", int'(q0), 9);
                chk("t1_tc_at9", int'(tc0), 1);
                chk("t1_ovf_before", int'(ovf0), 0);
            end
            if (i == 10) begin
                chk("t1_wrap_q", int'(q0), 0);
                chk("t1_wrap_pulse", int'(wrap0), 1);
                chk("t1_ovf_set", int'(ovf0), 1);
                chk("t1_sat_hold", int'(q1), 9);
            end
            if (i == 11) chk("t1_wrap_drop", int'(wrap0), 0);
        end
        chk("t1_end_q", int'(q0), 2);

        // 2: preset, then count down through the wrap
        step(0, 1, 0, 0, 0, 0);
        chk("t2_preset_q", int'(q0), 9);
        chk("t2_preset_ovf", int'(ovf0), 0);
        for (int i = 1; i <= 11; i++) begin
            step(0, 0, 0, 0, 1, 0);
            if (i == 9) chk("t2_q0_tc", int'(tc0), 1);
            if (i == 10) begin
                chk("t2_wrap_q", int'(q0), 9);
                chk("t2_wrap_pulse", int'(wrap0), 1);
                chk("t2_sat_q", int'(q1), 0);
            end
        end
        chk("t2_end_q", int'(q0), 8);

        // 3: saturating instance held at the top limit
        step(0, 0, 1, 8, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("t3_sat_q", int'(q1), 9);
            chk("t3_sat_nowrap", int'(wrap1), 0);
            chk("t3_sat_ovf", int'(ovf1), (i == 1) ? 0 : 1);
        end

        // 4: clamped load and priorities
        step(0, 0, 1, 200, 0, 1);
        chk("t4_clamp", int'(q0), 9);
        step(0, 0, 1, 4, 0, 1);
        chk("t4_load4", int'(q0), 4);
        step(1, 0, 1, 200, 1, 1);
        chk("t4_clear_wins", int'(q0), 0);
        step(0, 1, 1, 3, 1, 1);
        chk("t4_preset_wins", int'(q0), 9);

        // 5: clear mid-run, then hold
        step(0, 0, 0, 0, 1, 1);
        chk("t5_ovf_pre", int'(ovf0), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1);
        chk("t5_q5", int'(q0), 5);
        step(1, 0, 0, 0, 1, 1);
        chk("t5_clear_q", int'(q0), 0);
        chk("t5_clear_wrap", int'(wrap0), 0);
        chk("t5_clear_ovf", int'(ovf0), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("t5_hold_q", int'(q0), 0);

`ifdef COUNTER_MATCH_EN
        // 6: match on q==7 while counting up from 0
        step(1, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("t6_match", int'(match0), (i == 7) ? 1 : 0);
        end
`endif
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
